// File: rtl/report_scheduler.sv
// Round-robin scheduler for the four report-request channels sharing one formatter.
// Requests are latched as pending, granted one at a time, and each grant waits for the
// formatter's done pulse or a timeout before the next channel is considered.
module report_scheduler #(
   parameter int unsigned TIMEOUT_CYC = 1000000,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             iClk,
   input  logic             iRstn,
   input  logic             iReqWatchRpt,
   input  logic             iReqSr04Rpt,
   input  logic             iReqTempRpt,
   input  logic             iReqHumRpt,
   input  logic             iRptDone,
   input  logic             iClrErr,
   output logic             oRptStart,
   output logic [1:0]       oRptSel,
   output logic             oBusy,
   output logic [3:0]       oPending,
   output logic             oTimeoutErr,
   output logic [CNT_W-1:0] oCoalesceCnt
);

   localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TLast = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {StIdle, StStart, StWait, StGap} state_e;

   state_e           state_q, state_d;
   logic [3:0]       pending_q, pending_d;
   logic [1:0]       sel_q, sel_d;
   logic [1:0]       rr_q, rr_d;
   logic [TW-1:0]    tcnt_q, tcnt_d;
   logic             terr_q, terr_d;
   logic [CNT_W-1:0] coal_q, coal_d;
   logic             start_q, start_d;
   logic             busy_q, busy_d;

   logic [3:0] req;
   logic [3:0] clr;
   logic [1:0] pick;
   logic       timeout;
   logic       coal_hit;

   assign req = {iReqHumRpt, iReqTempRpt, iReqSr04Rpt, iReqWatchRpt};

   // First pending channel scanning from the round-robin pointer upward, mod 4
   always_comb begin
      logic       found;
      logic [1:0] idx;
      found = 1'b0;
      pick  = rr_q;
      idx   = rr_q;
      for (int i = 0; i < 4; i++) begin
         idx = rr_q + 2'(i);
         if (!found && pending_q[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   // FSM next state, grant bookkeeping and timeout counter
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      rr_d    = rr_q;
      tcnt_d  = tcnt_q;
      timeout = 1'b0;
      clr     = '0;
      unique case (state_q)
         StIdle: begin
            if (|pending_q) begin
               sel_d   = pick;
               state_d = StStart;
            end
         end
         StStart: begin
            clr[sel_q] = 1'b1;
            tcnt_d     = '0;
            state_d    = StWait;
         end
         StWait: begin
            // Done beats a coincident timeout
            if (iRptDone) begin
               state_d = StGap;
            end else if (tcnt_q == TLast) begin
               timeout = 1'b1;
               state_d = StGap;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         StGap: begin
            rr_d    = sel_q + 2'd1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Pending latch (set wins over clear), coalesce counter and sticky error
   always_comb begin
      pending_d = req | (pending_q & ~clr);
      coal_hit  = |(req & pending_q & ~clr);
      coal_d    = coal_q;
      if (iClrErr) begin
         coal_d = '0;
      end else if (coal_hit && (coal_q != {CNT_W{1'b1}})) begin
         coal_d = coal_q + CNT_W'(1);
      end
      terr_d = terr_q;
      if (timeout) begin
         terr_d = 1'b1;
      end else if (iClrErr) begin
         terr_d = 1'b0;
      end
      start_d = (state_d == StStart);
      busy_d  = (state_d != StIdle);
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge iClk) begin
      if (!iRstn) begin
         state_q   <= StIdle;
         pending_q <= '0;
         sel_q     <= '0;
         rr_q      <= '0;
         tcnt_q    <= '0;
         terr_q    <= 1'b0;
         coal_q    <= '0;
         start_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         sel_q     <= sel_d;
         rr_q      <= rr_d;
         tcnt_q    <= tcnt_d;
         terr_q    <= terr_d;
         coal_q    <= coal_d;
         start_q   <= start_d;
         busy_q    <= busy_d;
      end
   end

   assign oRptStart    = start_q;
   assign oRptSel      = sel_q;
   assign oBusy        = busy_q;
   assign oPending     = pending_q;
   assign oTimeoutErr  = terr_q;
   assign oCoalesceCnt = coal_q;

endmodule

// File: tb/tb_report_scheduler.sv
// Directed self-checking bench for report_scheduler (short timeout for quick runs).
module tb_report_scheduler;

   localparam int unsigned TimeoutCyc = 16;
   localparam int unsigned CntW       = 8;

   logic            iClk = 1'b0;
   logic            iRstn = 1'b0;
   logic            iReqWatchRpt = 1'b0;
   logic            iReqSr04Rpt = 1'b0;
   logic            iReqTempRpt = 1'b0;
   logic            iReqHumRpt = 1'b0;
   logic            iRptDone = 1'b0;
   logic            iClrErr = 1'b0;
   logic            oRptStart;
   logic [1:0]      oRptSel;
   logic            oBusy;
   logic [3:0]      oPending;
   logic            oTimeoutErr;
   logic [CntW-1:0] oCoalesceCnt;

   int n_cmp = 0;
   int n_err = 0;

   report_scheduler #(
      .TIMEOUT_CYC(TimeoutCyc),
      .CNT_W      (CntW)
   ) dut (
      .iClk        (iClk),
      .iRstn       (iRstn),
      .iReqWatchRpt(iReqWatchRpt),
      .iReqSr04Rpt (iReqSr04Rpt),
      .iReqTempRpt (iReqTempRpt),
      .iReqHumRpt  (iReqHumRpt),
      .iRptDone    (iRptDone),
      .iClrErr     (iClrErr),
      .oRptStart   (oRptStart),
      .oRptSel     (oRptSel),
      .oBusy       (oBusy),
      .oPending    (oPending),
      .oTimeoutErr (oTimeoutErr),
      .oCoalesceCnt(oCoalesceCnt)
   );

   always #5 iClk = ~iClk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One rising edge, then settle 1 time unit for sampling and driving
   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic set_req(input logic [3:0] r);
      {iReqHumRpt, iReqTempRpt, iReqSr04Rpt, iReqWatchRpt} = r;
   endtask

   task automatic pulse_req(input logic [3:0] r);
      set_req(r);
      tick();
      set_req(4'b0000);
   endtask

   task automatic wait_start(output int waited);
      waited = 0;
      while (!oRptStart && waited < 20) begin
         tick();
         waited++;
      end
      check("start_seen", 32'(oRptStart), 32'd1);
   endtask

   task automatic grant(input logic [1:0] ch);
      int w;
      wait_start(w);
      check("grant_sel", 32'(oRptSel), 32'(ch));
   endtask

   // n edges in START/WAIT, then a done pulse; checks GAP then IDLE
   task automatic finish(input int n);
      for (int i = 0; i < n; i++) tick();
      iRptDone = 1'b1;
      tick();
      iRptDone = 1'b0;
      check("gap_busy", 32'(oBusy), 32'd1);
      tick();
      check("idle_busy", 32'(oBusy), 32'd0);
   endtask

   task automatic do_reset();
      iRstn = 1'b0;
      tick();
      iRstn = 1'b1;
   endtask

   initial begin
      int w;
      int starts;

      // 1. Reset with requests active
      iRstn = 1'b0;
      set_req(4'b1111);
      repeat (3) tick();
      check("rst_pending", 32'(oPending), 32'h0);
      check("rst_start", 32'(oRptStart), 32'd0);
      check("rst_busy", 32'(oBusy), 32'd0);
      check("rst_sel", 32'(oRptSel), 32'd0);
      check("rst_terr", 32'(oTimeoutErr), 32'd0);
      check("rst_coal", 32'(oCoalesceCnt), 32'd0);
      set_req(4'b0000);
      iRstn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_after_rst", 32'(oBusy), 32'd0);
      end

      // 2. Single temperature request
      pulse_req(4'b0100);
      check("t2_pending", 32'(oPending), 32'b0100);
      check("t2_no_start", 32'(oRptStart), 32'd0);
      tick();
      check("t2_start", 32'(oRptStart), 32'd1);
      check("t2_sel", 32'(oRptSel), 32'd2);
      check("t2_busy", 32'(oBusy), 32'd1);
      tick();
      check("t2_start_1cyc", 32'(oRptStart), 32'd0);
      check("t2_pending_clr", 32'(oPending), 32'h0);
      finish(4);

      // 3. Round robin from rr=0
      do_reset();
      pulse_req(4'b1111);
      check("t3_pending", 32'(oPending), 32'b1111);
      for (int c = 0; c < 4; c++) begin
         wait_start(w);
         check("t3_order", 32'(oRptSel), 32'(c));
         check("t3_spacing", 32'(w), 32'd1);
         finish(3);
      end
      pulse_req(4'b1001);
      grant(2'd0);
      finish(3);
      wait_start(w);
      check("t3b_order", 32'(oRptSel), 32'd3);
      check("t3b_spacing", 32'(w), 32'd1);
      finish(3);

      // 4. Coalescing and set-wins (rr=0 here)
      pulse_req(4'b0001);
      grant(2'd0);
      tick();
      pulse_req(4'b0010);
      check("t4_pend1", 32'(oPending), 32'b0010);
      check("t4_coal0", 32'(oCoalesceCnt), 32'd0);
      pulse_req(4'b0010);
      check("t4_coal1", 32'(oCoalesceCnt), 32'd1);
      finish(1);
      grant(2'd1);
      finish(2);
      starts = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (oRptStart) starts++;
      end
      check("t4_single_grant", 32'(starts), 32'd0);
      pulse_req(4'b0010);
      grant(2'd1);
      pulse_req(4'b0010);
      check("t4_set_wins", 32'(oPending), 32'b0010);
      check("t4_no_coal_on_clr", 32'(oCoalesceCnt), 32'd1);
      finish(2);
      grant(2'd1);
      finish(1);
      iClrErr = 1'b1;
      tick();
      iClrErr = 1'b0;
      check("t4_coal_clr", 32'(oCoalesceCnt), 32'd0);

      // 5. Timeout (rr=2 here)
      pulse_req(4'b1100);
      grant(2'd2);
      tick();
      repeat (TimeoutCyc - 1) tick();
      check("t5_no_err_yet", 32'(oTimeoutErr), 32'd0);
      check("t5_still_busy", 32'(oBusy), 32'd1);
      tick();
      check("t5_err", 32'(oTimeoutErr), 32'd1);
      tick();
      check("t5_idle", 32'(oBusy), 32'd0);
      grant(2'd3);
      finish(1);
      check("t5_err_sticky", 32'(oTimeoutErr), 32'd1);
      iClrErr = 1'b1;
      tick();
      iClrErr = 1'b0;
      check("t5_err_clr", 32'(oTimeoutErr), 32'd0);
      pulse_req(4'b0001);
      grant(2'd0);
      tick();
      repeat (TimeoutCyc - 1) tick();
      iRptDone = 1'b1;
      tick();
      iRptDone = 1'b0;
      check("t5_done_wins", 32'(oTimeoutErr), 32'd0);
      check("t5_gap", 32'(oBusy), 32'd1);
      tick();

      // 6. Reset during WAIT (rr=1 here)
      pulse_req(4'b0010);
      grant(2'd1);
      tick();
      pulse_req(4'b1001);
      check("t6_pending", 32'(oPending), 32'b1001);
      do_reset();
      check("t6_pending_clr", 32'(oPending), 32'h0);
      check("t6_busy_clr", 32'(oBusy), 32'd0);
      starts = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (oRptStart) starts++;
      end
      check("t6_no_restart", 32'(starts), 32'd0);
      pulse_req(4'b1001);
      grant(2'd0);
      finish(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
